wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file, directly downstream of the EX/WB pipeline register. Each cycle it takes the registered writeback bundle, selects ALU result or immediate as write data, commits it to an 8-entry × 8-bit register file, and serves two combinational read ports to the decode stage. It also emits a registered commit record and a retired-instruction counter for trace and performance monitoring.

## Interface
- DATA_W, 8: register and datapath width
- ADDR_W, 3: register address width; file depth is 2**ADDR_W
- CNT_W, 16: retired-instruction counter width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- WB_RegWrite  in  1  write enable for this writeback
- WB_LoadImmediate  in  1  1 = write WB_ImmData, 0 = write WB_ALUres
- WB_ALUres  in  DATA_W  ALU result
- WB_ImmData  in  DATA_W  immediate data
- WB_writeReg  in  ADDR_W  destination register
- WB_instr  in  8  instruction in WB; 8'h00 is the bubble/NOP encoding
- ID_readReg1, ID_readReg2  in  ADDR_W  decode read addresses
- ID_readData1, ID_readData2  out  DATA_W  combinational read data
- commit_valid  out  1  registered one-cycle pulse: a write occurred last cycle
- commit_reg  out  ADDR_W  register written last cycle
- commit_data  out  DATA_W  value written last cycle
- retired_count  out  CNT_W  count of non-NOP instructions that reached WB

## Operation
- Write data: WB_LoadImmediate ? WB_ImmData : WB_ALUres.
- On rising clk with WB_RegWrite=1: regs[WB_writeReg] <= write data. All 8 registers writable; no hardwired zero register.
- WB_RegWrite=0: no register changes, regardless of other WB inputs.
- Reads: ID_readDataN = regs[ID_readRegN], pure combinational; both ports independent, same address on both allowed.
- Commit record: commit_valid <= WB_RegWrite; commit_reg/commit_data <= WB_writeReg/write data when WB_RegWrite=1, hold previous values otherwise.
- Retire counter: increments by 1 on each cycle with WB_instr != 8'h00, independent of WB_RegWrite; saturates at all-ones (no wrap).

## Timing
- Reset (async, rst=1): all 8 registers = 0, commit_valid=0, commit_reg=0, commit_data=0, retired_count=0; read ports therefore return 0 immediately.
- Write latency: value stored at the clock edge that samples WB_RegWrite=1; visible on read ports in the following cycle (same cycle only with bypass, see Configuration).
- Commit record lags the write by exactly one cycle.
- Back-to-back writes to the same register: last one wins; each produces its own commit pulse.
- rst asserted mid-cycle: state clears immediately; a write sampled at an edge coinciding with rst=1 is discarded.
- Counter at all-ones with non-NOP input: stays all-ones.

## Configuration
- WB_BYPASS_EN defined: if WB_RegWrite=1 and ID_readRegN == WB_writeReg, ID_readDataN returns the current write data in the same cycle (write-before-read); otherwise array value.
- WB_BYPASS_EN undefined: read ports return array contents only; same-cycle read of the register being written returns the old value. Decode must then stall or forward externally.

## Structure
- Shared package cpu_pkg: DATA_W, ADDR_W, NOP_INSTR (8'h00), word and register-address typedefs.
- One sub-module: wb_regarray (storage, reset clear, write port, two async read ports). Write-data mux, bypass, commit record and counter live in wb_regfile.

## Test plan
- Reset then read all 8 addresses on both ports -> all 0; commit_valid=0, retired_count=0.
- RegWrite=1, LoadImmediate=0, ALUres=8'h5A, writeReg=3, instr=8'h21 -> next cycle readReg1=3 gives 8'h5A, commit_valid=1, commit_reg=3, commit_data=8'h5A, retired_count=1.
- RegWrite=1, LoadImmediate=1, ImmData=8'hC3, ALUres=8'hFF, writeReg=7, readReg2=7 same cycle -> with WB_BYPASS_EN 8'hC3 same cycle; without, old value then 8'hC3 next cycle.
- RegWrite=0, writeReg=3, ALUres=8'h00, instr=8'h00 for 4 cycles -> reg 3 unchanged, commit_valid=0, retired_count unchanged.
- Preload counter path with 65 540 non-NOP cycles -> retired_count holds 16'hFFFF.
- Write 8'h11 to reg 2, assert rst mid-cycle before next edge -> reg 2 reads 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants for the writeback stage.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  count_t;
  typedef logic [7:0]        instr_t;

  localparam instr_t NOP_INSTR = 8'h00;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic count_t sat_inc(count_t value);
    return (value == '1) ? value : value + 1'b1;
  endfunction
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback/decode bus into the register file plus its commit-trace outputs.
interface wb_regfile_if;
  import cpu_pkg::*;

  logic      WB_RegWrite;
  logic      WB_LoadImmediate;
  word_t     WB_ALUres;
  word_t     WB_ImmData;
  reg_addr_t WB_writeReg;
  instr_t    WB_instr;
  reg_addr_t ID_readReg1;
  reg_addr_t ID_readReg2;
  word_t     ID_readData1;
  word_t     ID_readData2;
  logic      commit_valid;
  reg_addr_t commit_reg;
  word_t     commit_data;
  count_t    retired_count;

  modport master (
    output WB_RegWrite, WB_LoadImmediate, WB_ALUres, WB_ImmData, WB_writeReg,
           WB_instr, ID_readReg1, ID_readReg2,
    input  ID_readData1, ID_readData2, commit_valid, commit_reg, commit_data,
           retired_count
  );

  modport slave (
    input  WB_RegWrite, WB_LoadImmediate, WB_ALUres, WB_ImmData, WB_writeReg,
           WB_instr, ID_readReg1, ID_readReg2,
    output ID_readData1, ID_readData2, commit_valid, commit_reg, commit_data,
           retired_count
  );
endinterface

// File: rtl/wb_regarray.sv
// Architectural register storage: one synchronous write port, two asynchronous read ports.
module wb_regarray
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  output word_t     rdata1,
  output word_t     rdata2
);

  word_t regs [NREGS];

  // NOTE: the array is built from flops, not a RAM macro, so it can be cleared
  // by reset; sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: write-data select, register file, commit record, retire counter.
// Define WB_BYPASS_EN to forward the in-flight write to same-cycle reads.
module wb_regfile
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wb_regfile_if.slave    bus
);

  word_t wdata;
  word_t arr_data1;
  word_t arr_data2;

  assign wdata = bus.WB_LoadImmediate ? bus.WB_ImmData : bus.WB_ALUres;

  wb_regarray u_regarray (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.WB_RegWrite),
    .waddr  (bus.WB_writeReg),
    .wdata  (wdata),
    .raddr1 (bus.ID_readReg1),
    .raddr2 (bus.ID_readReg2),
    .rdata1 (arr_data1),
    .rdata2 (arr_data2)
  );

`ifdef WB_BYPASS_EN
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus.ID_readData1 = arr_data1;
    bus.ID_readData2 = arr_data2;
    if (bus.WB_RegWrite && (bus.ID_readReg1 == bus.WB_writeReg))
      bus.ID_readData1 = wdata;
    if (bus.WB_RegWrite && (bus.ID_readReg2 == bus.WB_writeReg))
      bus.ID_readData2 = wdata;
  end
`else
  // Decode sees the pre-write value of a register being written this cycle.
  assign bus.ID_readData1 = arr_data1;
  assign bus.ID_readData2 = arr_data2;
`endif

  // Commit record: valid pulses each write; register/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.commit_valid <= 1'b0;
      bus.commit_reg   <= '0;
      bus.commit_data  <= '0;
    end else begin
      bus.commit_valid <= bus.WB_RegWrite;
      if (bus.WB_RegWrite) begin
        bus.commit_reg  <= bus.WB_writeReg;
        bus.commit_data <= wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.retired_count <= '0;
    else if (bus.WB_instr != NOP_INSTR)
      bus.retired_count <= sat_inc(bus.retired_count);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against a high-level writeback model (works with or without WB_BYPASS_EN).
module tb_wb_regfile;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [7:0]  m_regs [8];
  logic        m_cv;
  logic [2:0]  m_cr;
  logic [7:0]  m_cd;
  logic [15:0] m_cnt;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_wdata();
    return bus.WB_LoadImmediate ? bus.WB_ImmData : bus.WB_ALUres;
  endfunction

  // What a decode read of ra should return right now, given the inputs on the bus.
  function automatic logic [7:0] m_read(logic [2:0] ra);
    if (BYPASS && bus.WB_RegWrite && ra == bus.WB_writeReg) return m_wdata();
    return m_regs[ra];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_cv = 1'b0; m_cr = 3'd0; m_cd = 8'h00; m_cnt = 16'h0000;
  endtask

  task automatic drive(logic we, logic li, logic [7:0] alu, logic [7:0] imm,
                       logic [2:0] wa, logic [7:0] instr);
    bus.WB_RegWrite = we; bus.WB_LoadImmediate = li;
    bus.WB_ALUres = alu;  bus.WB_ImmData = imm;
    bus.WB_writeReg = wa; bus.WB_instr = instr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00);
  endtask

  // Advance one edge, updating the model from the values sampled at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus.WB_RegWrite) begin
        m_regs[bus.WB_writeReg] = m_wdata();
        m_cr = bus.WB_writeReg;
        m_cd = m_wdata();
      end
      m_cv = bus.WB_RegWrite;
      if (bus.WB_instr != 8'h00 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic check_commit(string tag);
    checks++;
    if (bus.commit_valid !== m_cv || bus.commit_reg !== m_cr || bus.commit_data !== m_cd) begin
      failures++;
      $display("FAIL %s commit: got v=%0b r=%0d d=%h, want v=%0b r=%0d d=%h", tag,
               bus.commit_valid, bus.commit_reg, bus.commit_data, m_cv, m_cr, m_cd);
    end
    checks++;
    if (bus.retired_count !== m_cnt) begin
      failures++;
      $display("FAIL %s retired_count: got %h want %h", tag, bus.retired_count, m_cnt);
    end
  endtask

  task automatic test_reset();
    idle();
    bus.ID_readReg1 = 3'd0; bus.ID_readReg2 = 3'd0;
    #2 rst = 1'b1;
    m_reset();
    #3;
    for (int i = 0; i < 8; i++) begin
      bus.ID_readReg1 = 3'(i); bus.ID_readReg2 = 3'(7 - i);
      #1;
      checks++;
      if (bus.ID_readData1 !== 8'h00 || bus.ID_readData2 !== 8'h00) begin
        failures++;
        $display("FAIL reset_read addr=%0d: got %h/%h want 00/00", i, bus.ID_readData1, bus.ID_readData2);
      end
    end
    check_commit("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed_write();
    drive(1'b1, 1'b0, 8'h5A, 8'h00, 3'd3, 8'h21);
    tick();
    idle();
    bus.ID_readReg1 = 3'd3;
    #1;
    checks++;
    if (bus.ID_readData1 !== 8'h5A) begin
      failures++;
      $display("FAIL alu_write read: got %h want 5a", bus.ID_readData1);
    end
    checks++;
    if (bus.commit_valid !== 1'b1 || bus.commit_reg !== 3'd3 ||
        bus.commit_data !== 8'h5A || bus.retired_count !== 16'd1) begin
      failures++;
      $display("FAIL alu_write commit: got v=%0b r=%0d d=%h cnt=%0d want 1/3/5a/1",
               bus.commit_valid, bus.commit_reg, bus.commit_data, bus.retired_count);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] want;
    drive(1'b1, 1'b1, 8'hFF, 8'hC3, 3'd7, 8'h33);
    bus.ID_readReg2 = 3'd7;
    #1;
    want = BYPASS ? 8'hC3 : 8'h00;
    checks++;
    if (bus.ID_readData2 !== want) begin
      failures++;
      $display("FAIL same_cycle_read: got %h want %h", bus.ID_readData2, want);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.ID_readData2 !== 8'hC3) begin
      failures++;
      $display("FAIL imm_write next_cycle: got %h want c3", bus.ID_readData2);
    end
    check_commit("imm_write");
  endtask

  task automatic test_no_write();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd3, 8'h00);
    bus.ID_readReg1 = 3'd3;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.ID_readData1 !== 8'h5A) begin
        failures++;
        $display("FAIL no_write cycle %0d: reg3 got %h want 5a", c, bus.ID_readData1);
      end
      check_commit("no_write");
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 8'hA5, 8'h00, 3'd5, 8'h10);
    tick();
    check_commit("b2b_first");
    drive(1'b1, 1'b1, 8'h00, 8'h3C, 3'd5, 8'h11);
    tick();
    check_commit("b2b_second");
    idle();
    bus.ID_readReg1 = 3'd5;
    #1;
    checks++;
    if (bus.ID_readData1 !== 8'h3C) begin
      failures++;
      $display("FAIL b2b last_wins: got %h want 3c", bus.ID_readData1);
    end
  endtask

  task automatic test_random();
    logic [7:0] w1, w2;
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      bus.ID_readReg1 = 3'($urandom);
      bus.ID_readReg2 = ($urandom_range(0, 3) == 0) ? bus.WB_writeReg : 3'($urandom);
      #1;
      w1 = m_read(bus.ID_readReg1);
      w2 = m_read(bus.ID_readReg2);
      checks++;
      if (bus.ID_readData1 !== w1 || bus.ID_readData2 !== w2) begin
        failures++;
        $display("FAIL random_read n=%0d: got %h/%h want %h/%h", n,
                 bus.ID_readData1, bus.ID_readData2, w1, w2);
      end
      tick();
      check_commit("random");
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'hE7);
    for (int c = 0; c < 65540; c++) tick();
    checks++;
    if (bus.retired_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate: got %h want ffff", bus.retired_count);
    end
    tick();
    checks++;
    if (bus.retired_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate_hold: got %h want ffff", bus.retired_count);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 8'h11, 8'h00, 3'd2, 8'h01);
    tick();
    idle();
    bus.ID_readReg1 = 3'd2;
    #1;
    checks++;
    if (bus.ID_readData1 !== 8'h11) begin
      failures++;
      $display("FAIL pre_reset write: got %h want 11", bus.ID_readData1);
    end
    rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if (bus.ID_readData1 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset read: got %h want 00", bus.ID_readData1);
    end
    check_commit("mid_reset");
    // A write presented while reset is held must be discarded at the edge.
    drive(1'b1, 1'b1, 8'h00, 8'h77, 3'd4, 8'h02);
    bus.ID_readReg2 = 3'd4;
    tick();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ID_readData2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_edge_write: reg4 got %h want 00", bus.ID_readData2);
    end
    check_commit("reset_edge_write");
  endtask

  initial begin
    idle();
    bus.ID_readReg1 = 3'd0;
    bus.ID_readReg2 = 3'd0;
    m_reset();
    test_reset();
    test_directed_write();
    test_bypass();
    test_no_write();
    test_back_to_back();
    test_random();
    test_saturate();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
